// File: rtl/if_fetch_unit_if.sv
// Fetch-stage port bundle: imem read port, redirect input and IF/ID output triple.
// No storage; pure wiring between the fetch unit and its neighbours.
// master = fetch unit side, slave = memory / pipeline side.
interface if_fetch_unit_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_en;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;

    modport master (
        output imem_read, imem_address, if_valid, if_pc, if_pc_plus4, if_instr,
        input  imem_resp, imem_rdata, redirect, redirect_pc, ifid_en
    );

    modport slave (
        input  imem_read, imem_address, if_valid, if_pc, if_pc_plus4, if_instr,
        output imem_resp, imem_rdata, redirect, redirect_pc, ifid_en
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns fetch PC, one outstanding imem request, emits {pc, pc+4, instr}.
// Latency: output triple valid on the edge that samples imem_resp (visible next cycle).
// Backpressure: ifid_en low holds O, one more response parks in skid S, then requests stop.
// Optional macro IF_JAL_PREDICT_EN: follow JAL targets at fetch time.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h60,
    parameter logic [31:0] NOP_INSTR = 32'h13
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    // Address of the request being drained; pc already holds the redirect target.
    logic [31:0] drain_addr;

    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_instr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    logic        consume;
    logic        o_free;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign consume  = o_valid & bus.ifid_en;
    // O can take new data if it is empty or being handed to IF/ID this cycle.
    assign o_free   = ~o_valid | bus.ifid_en;
    assign pc_plus4 = pc + 32'd4;

`ifdef IF_JAL_PREDICT_EN
    logic [31:0] jal_imm;
    assign jal_imm = {{11{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[19:12],
                      bus.imem_rdata[20], bus.imem_rdata[30:21], 1'b0};
    assign next_pc = (bus.imem_rdata[6:0] == 7'h6F) ? pc + jal_imm : pc_plus4;
`else
    assign next_pc = pc_plus4;
`endif

    // Request is forced low during reset so nothing leaks out before the first edge.
    assign bus.imem_read    = rst_n & (state != ST_HOLD);
    assign bus.imem_address = (state == ST_DRAIN) ? drain_addr : pc;

    assign bus.if_valid    = o_valid;
    assign bus.if_pc       = o_pc;
    assign bus.if_pc_plus4 = o_pc_plus4;
    assign bus.if_instr    = o_instr;

    // Fetch FSM with output/skid registers; redirect overrides every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            o_valid    <= 1'b0;
            o_pc       <= RESET_PC;
            o_pc_plus4 <= RESET_PC + 32'd4;
            o_instr    <= NOP_INSTR;
            s_pc       <= 32'd0;
            s_instr    <= 32'd0;
        end else if (bus.redirect) begin
            o_valid <= 1'b0;
            o_instr <= NOP_INSTR;
            pc      <= bus.redirect_pc;
            case (state)
                ST_FETCH: begin
                    if (!bus.imem_resp) begin
                        // Request still outstanding: wait out its response.
                        state      <= ST_DRAIN;
                        drain_addr <= pc;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_DRAIN: state <= ST_DRAIN;
                default:  state <= ST_FETCH;
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    if (bus.imem_resp) begin
                        pc <= next_pc;
                        if (o_free) begin
                            o_valid    <= 1'b1;
                            o_pc       <= pc;
                            o_pc_plus4 <= pc_plus4;
                            o_instr    <= bus.imem_rdata;
                        end else begin
                            s_pc    <= pc;
                            s_instr <= bus.imem_rdata;
                            state   <= ST_HOLD;
                        end
                    end else if (consume) begin
                        o_valid <= 1'b0;
                        o_instr <= NOP_INSTR;
                    end
                end
                ST_HOLD: begin
                    if (consume) begin
                        o_valid    <= 1'b1;
                        o_pc       <= s_pc;
                        o_pc_plus4 <= s_pc + 32'd4;
                        o_instr    <= s_instr;
                        state      <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (bus.imem_resp) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model with random latency, instruction-stream scoreboard.
// Each cycle: sample at negedge, check, then drive memory and pipeline inputs.
// Directed scenarios from reset, back-pressure, redirects, wrap and JAL, then random soak.
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(32'h60), .NOP_INSTR(32'h13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          vectors = 0;
    int          errors  = 0;
    bit          busy;
    logic [31:0] maddr;
    int          cnt;
    int unsigned lat_max;
    logic [31:0] hold_addr;
    bit          jal_mode;
    logic [31:0] exp_pc;
    bit          after_redirect;
    logic [31:0] req_q[$];
    logic [31:0] cons_q[$];
    int          n_cons;
    int          total_cons;

    // Memory contents: pseudo-random words, never JAL unless jal_mode places one at 0x80.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (jal_mode && a == 32'h80) return 32'h0200006F;  // jal x0, +0x20
        w = (a * 32'h9E3779B1) ^ 32'h5A5A0000;
        return {w[31:7], 7'h13};
    endfunction

    // Address expected after the instruction at pc.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins);
        bit          predict;
        logic [31:0] imm;
        predict = 1'b0;
`ifdef IF_JAL_PREDICT_EN
        predict = 1'b1;
`endif
        imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        if (predict && ins[6:0] == 7'h6F) return pc + imm;
        return pc + 32'd4;
    endfunction

    // One clock cycle: check outputs, run the memory model, drive inputs for the next edge.
    task automatic tick(input bit en, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        if (bus.if_valid !== 1'b1) begin
            vectors++;
            if (bus.if_instr !== 32'h13) begin
                errors++;
                $display("FAIL nop_when_invalid: if_instr=%h required %h", bus.if_instr, 32'h13);
            end
        end
        if (after_redirect) begin
            vectors++;
            if (bus.if_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_after_redirect: if_valid=%b required 0", bus.if_valid);
            end
        end
        if (busy) begin
            vectors++;
            if (bus.imem_read !== 1'b1 || bus.imem_address !== maddr) begin
                errors++;
                $display("FAIL req_held: read=%b addr=%h required read=1 addr=%h",
                         bus.imem_read, bus.imem_address, maddr);
            end
        end
        if (bus.if_valid === 1'b1 && en && !rd) begin
            vectors++;
            if (bus.if_pc !== exp_pc || bus.if_pc_plus4 !== exp_pc + 32'd4 ||
                bus.if_instr !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL consume: pc=%h pc4=%h instr=%h required pc=%h pc4=%h instr=%h",
                         bus.if_pc, bus.if_pc_plus4, bus.if_instr,
                         exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
            end
            cons_q.push_back(bus.if_pc);
            n_cons++;
            total_cons++;
            exp_pc = model_next(exp_pc, mem_word(exp_pc));
        end
        bus.imem_resp = 1'b0;
        if (!busy && bus.imem_read === 1'b1) begin
            busy  = 1'b1;
            maddr = bus.imem_address;
            cnt   = int'($urandom_range(0, lat_max));
            req_q.push_back(maddr);
        end
        if (busy && maddr != hold_addr) begin
            if (cnt == 0) begin
                bus.imem_resp  = 1'b1;
                bus.imem_rdata = mem_word(maddr);
                busy           = 1'b0;
            end else begin
                cnt--;
            end
        end
        bus.ifid_en     = en;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        after_redirect  = rd;
        if (rd) begin
            exp_pc = rpc;
            req_q.delete();
        end
    endtask

    // Reset pulse with immediate check of reset values.
    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        busy            = 1'b0;
        bus.imem_resp   = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.ifid_en     = 1'b0;
        after_redirect  = 1'b0;
        #1;
        vectors++;
        if (bus.imem_read !== 1'b0 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h60 ||
            bus.if_pc_plus4 !== 32'h64 || bus.if_instr !== 32'h13) begin
            errors++;
            $display("FAIL reset_values: read=%b valid=%b pc=%h pc4=%h instr=%h required 0 0 60 64 13",
                     bus.imem_read, bus.if_valid, bus.if_pc, bus.if_pc_plus4, bus.if_instr);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        exp_pc    = 32'h60;
        hold_addr = 32'h1;
        jal_mode  = 1'b0;
        req_q.delete();
        cons_q.delete();
        n_cons = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (bus.imem_read !== 1'b1 || bus.imem_address !== 32'h60) begin
            errors++;
            $display("FAIL first_request: read=%b addr=%h required 1 00000060",
                     bus.imem_read, bus.imem_address);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        lat_max = 0;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 32'd0);
        vectors++;
        if (n_cons < 6) begin
            errors++;
            $display("FAIL seq_throughput: consumed=%0d required >=6", n_cons);
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (cons_q[i] !== 32'h60 + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL seq_order[%0d]: pc=%h required %h", i, cons_q[i], 32'h60 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_max = 0;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'd0);
        vectors++;
        if (bus.imem_read !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_pc !== 32'h60 ||
            req_q.size() != 2) begin
            errors++;
            $display("FAIL hold_state: read=%b valid=%b pc=%h reqs=%0d required 0 1 00000060 2",
                     bus.imem_read, bus.if_valid, bus.if_pc, req_q.size());
        end
        for (int i = 0; i < 20 && n_cons < 3; i++) tick(1'b1, 1'b0, 32'd0);
        vectors++;
        if (n_cons < 3 || cons_q[0] !== 32'h60 || cons_q[1] !== 32'h64 || cons_q[2] !== 32'h68) begin
            errors++;
            $display("FAIL hold_drain: consumed=%0d first=%h required 3 starting 60,64,68",
                     n_cons, (n_cons > 0) ? cons_q[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_outstanding();
        int c0;
        do_reset();
        lat_max   = 0;
        hold_addr = 32'h70;
        for (int i = 0; i < 30 && !(busy && maddr == 32'h70); i++) tick(1'b1, 1'b0, 32'd0);
        tick(1'b1, 1'b1, 32'h200);
        c0 = n_cons;
        tick(1'b1, 1'b0, 32'd0);
        vectors++;
        if (bus.if_valid !== 1'b0 || bus.imem_address !== 32'h70) begin
            errors++;
            $display("FAIL redir_drain: valid=%b addr=%h required 0 00000070", bus.if_valid, bus.imem_address);
        end
        hold_addr = 32'h1;
        for (int i = 0; i < 20 && n_cons <= c0; i++) tick(1'b1, 1'b0, 32'd0);
        vectors++;
        if (n_cons <= c0 || req_q.size() == 0 || req_q[0] !== 32'h200 || cons_q[c0] !== 32'h200) begin
            errors++;
            $display("FAIL redir_target: first_req=%h first_pc=%h required 00000200",
                     (req_q.size() > 0) ? req_q[0] : 32'hx, (n_cons > c0) ? cons_q[c0] : 32'hx);
        end
    endtask

    task automatic test_redirect_with_resp();
        do_reset();
        lat_max   = 0;
        hold_addr = 32'h64;
        for (int i = 0; i < 30 && !(busy && maddr == 32'h64); i++) tick(1'b1, 1'b0, 32'd0);
        hold_addr = 32'h1;
        tick(1'b1, 1'b1, 32'h240);
        tick(1'b1, 1'b0, 32'd0);
        vectors++;
        if (bus.if_valid !== 1'b0 || bus.imem_read !== 1'b1 || bus.imem_address !== 32'h240) begin
            errors++;
            $display("FAIL redir_same_cycle: valid=%b read=%b addr=%h required 0 1 00000240",
                     bus.if_valid, bus.imem_read, bus.imem_address);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_double_redirect();
        int c0;
        do_reset();
        lat_max   = 0;
        hold_addr = 32'h68;
        for (int i = 0; i < 30 && !(busy && maddr == 32'h68); i++) tick(1'b1, 1'b0, 32'd0);
        tick(1'b1, 1'b1, 32'h300);
        tick(1'b1, 1'b1, 32'h400);
        vectors++;
        if (bus.imem_read !== 1'b1 || bus.imem_address !== 32'h68) begin
            errors++;
            $display("FAIL drain_addr: read=%b addr=%h required 1 00000068", bus.imem_read, bus.imem_address);
        end
        c0 = n_cons;
        hold_addr = 32'h1;
        for (int i = 0; i < 20 && n_cons <= c0; i++) tick(1'b1, 1'b0, 32'd0);
        vectors++;
        if (n_cons <= c0 || req_q.size() == 0 || req_q[0] !== 32'h400 || cons_q[c0] !== 32'h400) begin
            errors++;
            $display("FAIL double_redir: first_req=%h first_pc=%h required 00000400",
                     (req_q.size() > 0) ? req_q[0] : 32'hx, (n_cons > c0) ? cons_q[c0] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat_max = 1;
        tick(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 40 && n_cons < 3; i++) tick(1'b1, 1'b0, 32'd0);
        vectors++;
        if (n_cons < 3 || cons_q[0] !== 32'hFFFF_FFF8 || cons_q[1] !== 32'hFFFF_FFFC || cons_q[2] !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: consumed=%0d required FFFFFFF8,FFFFFFFC,00000000", n_cons);
        end
    endtask

    task automatic test_jal();
        logic [31:0] want;
        logic [31:0] got;
        bit          found;
`ifdef IF_JAL_PREDICT_EN
        want = 32'hA0;
`else
        want = 32'h84;
`endif
        do_reset();
        jal_mode = 1'b1;
        lat_max  = 0;
        found    = 1'b0;
        got      = 32'hx;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1'b1, 1'b0, 32'd0);
            for (int k = 0; k + 1 < req_q.size(); k++) begin
                if (req_q[k] == 32'h80 && !found) begin
                    found = 1'b1;
                    got   = req_q[k + 1];
                end
            end
        end
        vectors++;
        if (!found || got !== want) begin
            errors++;
            $display("FAIL jal_next: next_req=%h required %h", got, want);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'd0);
        jal_mode = 1'b0;
    endtask

    task automatic test_random();
        bit          en;
        bit          rd;
        logic [31:0] rpc;
        int          start;
        do_reset();
        lat_max = 2;
        start   = total_cons;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                lat_max = 2;
            end
            en  = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 24) == 0);
            rpc = 32'($urandom_range(0, 1023)) << 2;
            tick(en, rd, rpc);
        end
        vectors++;
        if (total_cons - start < 300) begin
            errors++;
            $display("FAIL random_progress: consumed=%0d required >=300", total_cons - start);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        busy            = 1'b0;
        maddr           = 32'd0;
        cnt             = 0;
        lat_max         = 0;
        hold_addr       = 32'h1;
        jal_mode        = 1'b0;
        exp_pc          = 32'h60;
        after_redirect  = 1'b0;
        n_cons          = 0;
        total_cons      = 0;
        bus.imem_resp   = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.ifid_en     = 1'b0;

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_with_resp();
        test_double_redirect();
        test_wrap();
        test_jal();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
